// File: rtl/instr_encoder_if.sv
// instr_encoder_if -- request, control and instruction-memory signals of the
// instruction encoder, grouped into one bundle.
//   ReqValid/ReqReady                 request handshake
//   Mnemonic, Rs, Rt, Rd, Shamt       operation code and register/shift fields
//   Imm, Target                       immediate and jump-target fields
//   Start, BaseAddr                   program restart and load address
//   MemWrite, MemAddr, MemData        instruction-memory write port (out)
//   MemReady                          memory accepts the write (in)
//   Illegal, Count, Busy              status
// master = request/memory side, slave = encoder.
interface instr_encoder_if;
  logic        ReqValid;
  logic        ReqReady;
  logic [4:0]  Mnemonic;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic [4:0]  Shamt;
  logic [15:0] Imm;
  logic [25:0] Target;
  logic        Start;
  logic [31:0] BaseAddr;
  logic        MemWrite;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic        MemReady;
  logic        Illegal;
  logic [15:0] Count;
  logic        Busy;

  modport master (
    output ReqValid, Mnemonic, Rs, Rt, Rd, Shamt, Imm, Target,
           Start, BaseAddr, MemReady,
    input  ReqReady, MemWrite, MemAddr, MemData, Illegal, Count, Busy
  );

  modport slave (
    input  ReqValid, Mnemonic, Rs, Rt, Rd, Shamt, Imm, Target,
           Start, BaseAddr, MemReady,
    output ReqReady, MemWrite, MemAddr, MemData, Illegal, Count, Busy
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder -- accepts one instruction request at a time, encodes it into
// a 32-bit MIPS-style word and writes it to instruction memory at a
// self-incrementing address.
// Ports:
//   Clk   rising-edge clock
//   Rst   asynchronous active-low reset
//   bus   instr_encoder_if.slave (request, memory write port, status)
// FSM: IDLE -> ENC -> WR -> IDLE (illegal opcodes return from ENC to IDLE).
// Build option: define INSTR_ENC_SHIFT_EN to enable sll/srl (mnemonics 7-8);
// without it those mnemonics are treated as illegal.
module instr_encoder (
  input  logic            Clk,
  input  logic            Rst,
  instr_encoder_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ENC = 2'd1, S_WR = 2'd2} state_t;

  state_t      state_q, state_d;

  logic [4:0]  mnem_q, rs_q, rt_q, rd_q, shamt_q;
  logic [15:0] imm_q;
  logic [25:0] tgt_q;
  logic [31:0] addr_q, data_q;
  logic [15:0] count_q;
  logic        illegal_q;

  // encoder outputs
  logic [5:0]  op, funct;
  logic [4:0]  f_rs, f_rt, f_rd;
  logic        legal, is_i, is_j, is_shift;
  logic [31:0] word;

  logic        start_idle, accept;

  assign start_idle = (state_q == S_IDLE) && bus.Start;
  // Start has priority over a simultaneous request
  assign accept     = (state_q == S_IDLE) && !bus.Start && bus.ReqValid;

  // ---------------------------------------------------------------- encoder
  always_comb begin
    op       = 6'b000000;
    funct    = 6'b000000;
    f_rs     = rs_q;
    f_rt     = rt_q;
    f_rd     = rd_q;
    legal    = 1'b1;
    is_i     = 1'b0;
    is_j     = 1'b0;
    is_shift = 1'b0;
    case (mnem_q)
      5'd0:  funct = 6'b100000;
      5'd1:  funct = 6'b100010;
      5'd2:  funct = 6'b100100;
      5'd3:  funct = 6'b100101;
      5'd4:  funct = 6'b100110;
      5'd5:  funct = 6'b100111;
      5'd6:  funct = 6'b101010;
`ifdef INSTR_ENC_SHIFT_EN
      5'd7:  begin funct = 6'b000000; f_rs = 5'd0; is_shift = 1'b1; end
      5'd8:  begin funct = 6'b000010; f_rs = 5'd0; is_shift = 1'b1; end
`else
      5'd7, 5'd8: legal = 1'b0;
`endif
      5'd9:  begin funct = 6'b001000; f_rt = 5'd0; f_rd = 5'd0; end
      5'd10: begin op = 6'b011100; funct = 6'b000010; end
      5'd11: begin op = 6'b001000; is_i = 1'b1; end
      5'd12: begin op = 6'b001100; is_i = 1'b1; end
      5'd13: begin op = 6'b001101; is_i = 1'b1; end
      5'd14: begin op = 6'b001110; is_i = 1'b1; end
      5'd15: begin op = 6'b001010; is_i = 1'b1; end
      5'd16: begin op = 6'b100011; is_i = 1'b1; end
      5'd17: begin op = 6'b101011; is_i = 1'b1; end
      5'd18: begin op = 6'b100000; is_i = 1'b1; end
      5'd19: begin op = 6'b100001; is_i = 1'b1; end
      5'd20: begin op = 6'b101000; is_i = 1'b1; end
      5'd21: begin op = 6'b101001; is_i = 1'b1; end
      5'd22: begin op = 6'b000100; is_i = 1'b1; end
      5'd23: begin op = 6'b000101; is_i = 1'b1; end
      5'd24: begin op = 6'b000111; is_i = 1'b1; f_rt = 5'd0; end
      5'd25: begin op = 6'b000110; is_i = 1'b1; f_rt = 5'd0; end
      // REGIMM: the rt field selects bltz/bgez
      5'd26: begin op = 6'b000001; is_i = 1'b1; f_rt = 5'd0; end
      5'd27: begin op = 6'b000001; is_i = 1'b1; f_rt = 5'd1; end
      5'd28: begin op = 6'b000010; is_j = 1'b1; end
      5'd29: begin op = 6'b000011; is_j = 1'b1; end
      default: legal = 1'b0;
    endcase

    if (is_j)
      word = {op, tgt_q};
    else if (is_i)
      word = {op, f_rs, f_rt, imm_q};
    else
      word = {op, f_rs, f_rt, f_rd, (is_shift ? shamt_q : 5'd0), funct};
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)       state_d = S_ENC;
      S_ENC:   state_d = legal ? S_WR : S_IDLE;
      S_WR:    if (bus.MemReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ReqReady = (state_q == S_IDLE) && !bus.Start;
    bus.MemWrite = (state_q == S_WR);
    bus.Busy     = (state_q != S_IDLE);
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mnem_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      shamt_q   <= '0;
      imm_q     <= '0;
      tgt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (start_idle) begin
        addr_q    <= bus.BaseAddr & ~32'd3;
        count_q   <= '0;
        illegal_q <= 1'b0;
      end
      if (accept) begin
        mnem_q  <= bus.Mnemonic;
        rs_q    <= bus.Rs;
        rt_q    <= bus.Rt;
        rd_q    <= bus.Rd;
        shamt_q <= bus.Shamt;
        imm_q   <= bus.Imm;
        tgt_q   <= bus.Target;
      end
      if (state_q == S_ENC) begin
        if (legal) data_q    <= word;
        else       illegal_q <= 1'b1;
      end
      if (state_q == S_WR && bus.MemReady) begin
        addr_q  <= addr_q + 32'd4;   // natural 32-bit wrap past 0xFFFFFFFC
        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      end
    end
  end

  assign bus.MemAddr = addr_q;
  assign bus.MemData = data_q;
  assign bus.Count   = count_q;
  assign bus.Illegal = illegal_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  instr_encoder_if bus ();

  instr_encoder dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: every accepted memory write must match the next expected word
  always @(negedge Clk) begin
    if (Rst && bus.MemWrite && bus.MemReady) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_write: got addr %h data %h want no write",
                 bus.MemAddr, bus.MemData);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", bus.MemAddr, e.a);
        chk("wr_data", bus.MemData, e.d);
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh,
                      input logic [15:0] imm, input logic [25:0] tgt);
    int n;
    @(posedge Clk); #1;
    bus.Mnemonic = mn; bus.Rs = rs; bus.Rt = rt; bus.Rd = rd;
    bus.Shamt = sh; bus.Imm = imm; bus.Target = tgt;
    bus.ReqValid = 1'b1;
    n = 0;
    while (!bus.ReqReady && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n == 20) chk("req_ready_timeout", 32'(bus.ReqReady), 32'd1);
    @(posedge Clk); #1;
    bus.ReqValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.Busy && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n == 50) chk("idle_timeout", 32'(bus.Busy), 32'd0);
  endtask

  task automatic wait_wr();
    int n;
    n = 0;
    while (!bus.MemWrite && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n == 20) chk("memwrite_timeout", 32'(bus.MemWrite), 32'd1);
  endtask

  task automatic start(input logic [31:0] base);
    @(posedge Clk); #1;
    bus.Start = 1'b1; bus.BaseAddr = base;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
  endtask

  initial begin
    bus.ReqValid = 1'b0; bus.Mnemonic = '0; bus.Rs = '0; bus.Rt = '0; bus.Rd = '0;
    bus.Shamt = '0; bus.Imm = '0; bus.Target = '0; bus.Start = 1'b0;
    bus.BaseAddr = '0; bus.MemReady = 1'b1;

    // reset state
    #12;
    chk("rst_ready",    32'(bus.ReqReady), 32'd1);
    chk("rst_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("rst_addr",     bus.MemAddr,       32'd0);
    chk("rst_data",     bus.MemData,       32'd0);
    chk("rst_count",    32'(bus.Count),    32'd0);
    chk("rst_illegal",  32'(bus.Illegal),  32'd0);
    chk("rst_busy",     32'(bus.Busy),     32'd0);
    @(posedge Clk); #1; Rst = 1'b1;

    // Start aligns the base address; first word is add
    start(32'h0000_0102);
    chk("start_addr", bus.MemAddr, 32'h0000_0100);
    push(32'h0000_0100, 32'h0022_1820);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    wait_idle();
    chk("add_count", 32'(bus.Count), 32'd1);

    // lw then j at consecutive addresses
    push(32'h0000_0104, 32'h8FA8_FFFC);
    send(5'd16, 5'd29, 5'd8, 5'd0, 5'd0, 16'hFFFC, 26'h0);
    wait_idle();
    push(32'h0000_0108, 32'h0800_0010);
    send(5'd28, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0010);
    wait_idle();
    chk("j_count", 32'(bus.Count), 32'd3);

    // bgez with rt forced to 1; memory stalls for 5 cycles
    bus.MemReady = 1'b0;
    push(32'h0000_010C, 32'h0481_0003);
    send(5'd27, 5'd4, 5'd7, 5'd0, 5'd0, 16'h0003, 26'h0);
    wait_wr();
    for (int i = 0; i < 5; i++) begin
      chk("stall_memwrite", 32'(bus.MemWrite), 32'd1);
      chk("stall_data",     bus.MemData,       32'h0481_0003);
      chk("stall_addr",     bus.MemAddr,       32'h0000_010C);
      @(posedge Clk); #1;
    end
    bus.MemReady = 1'b1;
    wait_idle();
    chk("bgez_count", 32'(bus.Count), 32'd4);

    // illegal mnemonic: no write, sticky flag, Start clears it
    send(5'd31, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
    wait_idle();
    chk("ill_flag",  32'(bus.Illegal), 32'd1);
    chk("ill_count", 32'(bus.Count),   32'd4);
    chk("ill_addr",  bus.MemAddr,      32'h0000_0110);
    start(32'h0000_0200);
    chk("ill_clear",  32'(bus.Illegal), 32'd0);
    chk("start_cnt0", 32'(bus.Count),   32'd0);

    // sll depends on build option
`ifdef INSTR_ENC_SHIFT_EN
    push(32'h0000_0200, 32'h0002_2900);
    send(5'd7, 5'd9, 5'd2, 5'd5, 5'd4, 16'h0, 26'h0);
    wait_idle();
    chk("sll_count",   32'(bus.Count),   32'd1);
    chk("sll_illegal", 32'(bus.Illegal), 32'd0);
`else
    send(5'd7, 5'd9, 5'd2, 5'd5, 5'd4, 16'h0, 26'h0);
    wait_idle();
    chk("sll_count",   32'(bus.Count),   32'd0);
    chk("sll_illegal", 32'(bus.Illegal), 32'd1);
`endif

    // Start and ReqValid together: Start wins, no request accepted
    @(posedge Clk); #1;
    bus.Start = 1'b1; bus.BaseAddr = 32'h0000_0300;
    bus.Mnemonic = 5'd0; bus.ReqValid = 1'b1;
    #1;
    chk("collide_ready", 32'(bus.ReqReady), 32'd0);
    @(posedge Clk); #1;
    bus.Start = 1'b0; bus.ReqValid = 1'b0;
    chk("collide_busy", 32'(bus.Busy),   32'd0);
    chk("collide_addr", bus.MemAddr,     32'h0000_0300);
    chk("collide_ill",  32'(bus.Illegal), 32'd0);

    // bltz forces rt=0; jr forces rt/rd/shamt=0
    push(32'h0000_0300, 32'h0460_8000);
    send(5'd26, 5'd3, 5'd9, 5'd0, 5'd0, 16'h8000, 26'h0);
    wait_idle();
    push(32'h0000_0304, 32'h03E0_0008);
    send(5'd9, 5'd31, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0);
    wait_idle();
    chk("jr_count", 32'(bus.Count), 32'd2);

    // address wrap
    start(32'hFFFF_FFFF);
    chk("wrap_base", bus.MemAddr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC, 32'h00A6_3825);
    send(5'd3, 5'd5, 5'd6, 5'd7, 5'd0, 16'h0, 26'h0);
    wait_idle();
    push(32'h0000_0000, 32'h03E0_0822);
    send(5'd1, 5'd31, 5'd0, 5'd1, 5'd0, 16'h0, 26'h0);
    wait_idle();
    chk("wrap_addr",  bus.MemAddr,    32'h0000_0004);
    chk("wrap_count", 32'(bus.Count), 32'd2);

    // reset while a write is pending
    bus.MemReady = 1'b0;
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    wait_wr();
    Rst = 1'b0;
    #1;
    chk("rstwr_memwrite", 32'(bus.MemWrite), 32'd0);
    chk("rstwr_count",    32'(bus.Count),    32'd0);
    chk("rstwr_busy",     32'(bus.Busy),     32'd0);
    chk("rstwr_ready",    32'(bus.ReqReady), 32'd1);
    chk("rstwr_addr",     bus.MemAddr,       32'd0);
    @(posedge Clk); #1;
    bus.MemReady = 1'b1;
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
